prog_mem_loader: RTL
====================

Name: prog_mem_loader

Overview:
- Write-side counterpart to the CPU instruction-fetch path.
- Receives a framed byte stream (sync, word count, instruction words, optional checksum) over a valid/ready byte interface.
- Packs each pair of bytes into one 12-bit instruction and writes it sequentially from address 0 into the 9-bit-addressed program memory.
- Holds the CPU (PC/IR clear) while a load is in progress.

Parameters:
ADDR_W, 9, program memory address width
INSTR_W, 12, instruction word width
SYNC_BYTE, 8'hA5, frame start marker

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  asynchronous reset, active-high
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a CLK edge
pm_addr  out  ADDR_W  program memory write address
pm_data  out  INSTR_W  program memory write data
pm_we  out  1  program memory write strobe, one cycle per word
cpu_hold  out  1  holds the CPU in reset while high
done  out  1  load completed successfully; level signal
error  out  1  frame error; level signal

Behaviour:
- Clock and reset: one clock, CLK. CLR is asynchronous and active-high.
- Reset values: state IDLE, rx_ready=1, pm_addr=0, pm_data=0, pm_we=0, cpu_hold=0, done=0, error=0, word counter=0, checksum accumulator=0.
- States: IDLE, CNT_LO, CNT_HI, W_LO, W_HI, WRITE, CHK (CHECKSUM_EN only), DONE, ERR.
- rx_ready is 1 in every state except WRITE, where it is 0 for exactly one cycle.
- IDLE, DONE and ERR:
  - Bytes other than SYNC_BYTE are accepted and discarded.
  - SYNC_BYTE -> CNT_LO. On the same edge: cpu_hold<=1, done<=0, error<=0, pm_addr<=0, accumulator<=0.
- CNT_LO: byte -> count[7:0]; go to CNT_HI.
- CNT_HI:
  - bit0 -> count[8]. Bits 7:1 nonzero -> ERR.
  - count==0 -> CHK if CHECKSUM_EN is defined, else DONE.
  - Otherwise -> W_LO.
- W_LO: byte -> pm_data[7:0]; go to W_HI.
- W_HI:
  - byte[3:0] -> pm_data[11:8]. byte[7:4] nonzero -> ERR, and no write occurs.
  - Otherwise -> WRITE.
- Inside a frame, SYNC_BYTE is ordinary data. There is no resync mid-frame.
- WRITE:
  - pm_we=1 for this single cycle; pm_addr and pm_data are stable during it.
  - On exit: pm_addr<=pm_addr+1, words_written<=words_written+1.
  - If words_written+1==count -> CHK (or DONE when CHECKSUM_EN is not defined); else W_LO.
  - Write latency: pm_we asserts in the cycle after the high byte is accepted.
- DONE: done=1, cpu_hold=0. The CPU restarts from PC 0.
- ERR: error=1, cpu_hold stays 1. Memory contents are undefined; the host must resend the frame.
- Width rules:
  - count range is 0..511. pm_addr never wraps because the maximum address written is 510.
  - pm_addr increments modulo 2^ADDR_W.
- Reset mid-load: immediate return to reset values; cpu_hold drops. Partially written memory is not erased.
- pm_we is never asserted outside WRITE.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - The accumulator sums every byte after sync, modulo 256 (count bytes and word bytes).
  - After the last WRITE, or from CNT_HI when count==0, the state goes to CHK.
  - CHK accepts one byte. If accumulator+byte==8'h00 -> DONE, else -> ERR.
- Not defined:
  - No CHK state and no accumulator logic.
  - The last WRITE goes directly to DONE, and count==0 goes directly to DONE.

Test Plan:
1. Basic load, checksum enabled. Bytes A5 02 00 23 01 BC 0A 14 -> writes 0x123@0 and 0xABC@1, one pm_we cycle each; done=1; cpu_hold=0; error=0.
2. Leading garbage. Bytes 00 FF 5A, then the frame from test 1 -> the first three bytes are ignored with no pm_we; result identical to test 1.
3. Bad high nibble. Bytes A5 01 00 34 F2 -> no pm_we; error=1; cpu_hold=1. A following valid frame clears error and loads normally.
4. Checksum mismatch. Frame from test 1 with last byte 15 -> both words written, then error=1, done=0, cpu_hold=1. Without the macro, the same frame minus the checksum byte ends in done=1.
5. Backpressure and empty frame:
   - rx_valid held high continuously during test 1 -> rx_ready=0 in each WRITE cycle and no byte is lost.
   - Bytes A5 00 00 00 -> done=1 with zero writes.
6. Async reset. Assert CLR after the third word byte of a 4-word frame -> all outputs return to reset values immediately (not at the next edge); pm_addr=0; the next full frame loads correctly.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: framed byte-stream loader for the CPU program memory.
// Frame: SYNC_BYTE, count lo, count hi (bit0 only), count x {lo, hi} word bytes,
// then one checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
// Each pair of word bytes becomes one 12-bit instruction. Instructions are
// written to consecutive addresses starting at 0. cpu_hold stays high for the
// whole load.
//
// Handshake: a byte transfers on a rising CLK edge where rx_valid && rx_ready.
// rx_ready is registered. It drops for exactly the one WRITE cycle and is high
// in every other state.
//
// state_dbg exposes the FSM state so that checkers can bind to it.
module prog_mem_loader #(
  parameter int          ADDR_W    = 9,
  parameter int          INSTR_W   = 12,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_data,
  output logic               pm_we,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CNT_LO = 4'd1,
    CNT_HI = 4'd2,
    W_LO   = 4'd3,
    W_HI   = 4'd4,
    WRITE  = 4'd5,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK    = 4'd6,
`endif
    DONE   = 4'd7,
    ERR    = 4'd8
  } state_t;

  state_t     state;
  logic [8:0] count;
  logic [8:0] words_written;
  logic       accept;

  assign accept    = rx_valid && rx_ready;
  assign state_dbg = state;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic [7:0] chk_sum;

  assign chk_sum = acc + rx_data;

  // Running modulo-256 sum of every count and word byte after the sync byte.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      acc <= 8'h00;
    end else if (accept) begin
      case (state)
        IDLE, DONE, ERR: if (rx_data == SYNC_BYTE) acc <= 8'h00;
        CNT_LO, CNT_HI, W_LO, W_HI: acc <= acc + rx_data;
        default: ;
      endcase
    end
  end
`endif

  // Frame parser FSM with registered handshake, write strobe and status outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state         <= IDLE;
      rx_ready      <= 1'b1;
      pm_addr       <= '0;
      pm_data       <= '0;
      pm_we         <= 1'b0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      count         <= '0;
      words_written <= '0;
    end else begin
      pm_we    <= 1'b0;
      rx_ready <= 1'b1;
      case (state)
        IDLE, DONE, ERR: begin
          // Non-sync bytes are consumed and dropped while waiting for a frame.
          if (accept && rx_data == SYNC_BYTE) begin
            state         <= CNT_LO;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            pm_addr       <= '0;
            words_written <= '0;
          end
        end
        CNT_LO: begin
          if (accept) begin
            count[7:0] <= rx_data;
            state      <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (accept) begin
            count[8] <= rx_data[0];
            if (rx_data[7:1] != 7'd0) begin
              state <= ERR;
              error <= 1'b1;
            end else if ({rx_data[0], count[7:0]} == 9'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state <= W_LO;
            end
          end
        end
        W_LO: begin
          if (accept) begin
            pm_data[7:0] <= rx_data;
            state        <= W_HI;
          end
        end
        W_HI: begin
          if (accept) begin
            if (rx_data[7:4] != 4'd0) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              pm_data[INSTR_W-1:8] <= rx_data[INSTR_W-9:0];
              state                <= WRITE;
              pm_we                <= 1'b1;
              rx_ready             <= 1'b0;
            end
          end
        end
        WRITE: begin
          pm_addr       <= pm_addr + ADDR_W'(1);
          words_written <= words_written + 9'd1;
          if ((words_written + 9'd1) == count) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state <= W_LO;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (chk_sum == 8'h00) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
